// File: rtl/ram_slot_scheduler.sv
// Time-division SRAM scheduler: one 64-clock CPU cycle split into eight
// 8-clock slots shared by video fetch, the 6502 CPU and a Wishbone master.
// Every slot is decided on the edge that starts it and held until the next.
module ram_slot_scheduler #(
   parameter int unsigned RAM_ADDR_WIDTH = 17,
   parameter int unsigned DATA_WIDTH     = 8
) (
   input  logic                      clock_i,
   input  logic                      reset_i,
   output logic                      cpu_phi2_o,
   input  logic                      cpu_en_i,
   input  logic                      cpu_we_i,
   input  logic [RAM_ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [DATA_WIDTH-1:0]     cpu_data_i,
   output logic [DATA_WIDTH-1:0]     cpu_data_o,
   input  logic                      video_en_i,
   input  logic [RAM_ADDR_WIDTH-1:0] video_char_addr_i,
   input  logic [RAM_ADDR_WIDTH-1:0] video_pixel_addr_i,
   output logic [DATA_WIDTH-1:0]     video_data_o,
   output logic                      video_char_strobe_o,
   output logic                      video_pixel_strobe_o,
   input  logic                      wb_cyc_i,
   input  logic                      wb_stb_i,
   input  logic                      wb_we_i,
   input  logic [RAM_ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [DATA_WIDTH-1:0]     wb_dat_i,
   output logic [DATA_WIDTH-1:0]     wb_dat_o,
   output logic                      wb_ack_o,
   output logic [RAM_ADDR_WIDTH-1:0] ram_addr_o,
   output logic [DATA_WIDTH-1:0]     ram_data_o,
   input  logic [DATA_WIDTH-1:0]     ram_data_i,
   output logic                      ram_oe_o,
   output logic                      ram_we_o
);

   localparam int unsigned PHASE_WIDTH = 6;
   localparam int unsigned SLOT_WIDTH  = 3;

   localparam logic [SLOT_WIDTH-1:0] SLOT_CHAR  = SLOT_WIDTH'(0);
   localparam logic [SLOT_WIDTH-1:0] SLOT_PIXEL = SLOT_WIDTH'(1);
   localparam logic [SLOT_WIDTH-1:0] SLOT_CPU   = SLOT_WIDTH'(5);

   localparam logic [SLOT_WIDTH-1:0] SUB_START    = SLOT_WIDTH'(0);
   localparam logic [SLOT_WIDTH-1:0] SUB_WE_FIRST = SLOT_WIDTH'(2);
   localparam logic [SLOT_WIDTH-1:0] SUB_WE_LAST  = SLOT_WIDTH'(5);
   localparam logic [SLOT_WIDTH-1:0] SUB_DONE     = SLOT_WIDTH'(7);

   typedef enum logic [2:0] {
      OWN_IDLE,
      OWN_CHAR,
      OWN_PIXEL,
      OWN_CPU,
      OWN_WB
   } owner_t;

   logic [PHASE_WIDTH-1:0]    phase_q;
   logic [PHASE_WIDTH-1:0]    phase_d;
   owner_t                    owner_q;
   owner_t                    owner_d;
   logic                      we_q;
   logic                      we_d;
   logic [SLOT_WIDTH-1:0]     slot_n;
   logic [SLOT_WIDTH-1:0]     sub_n;

   logic                      phi2_d;
   logic                      oe_d;
   logic                      wen_d;
   logic                      char_stb_d;
   logic                      pixel_stb_d;
   logic                      ack_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_d;
   logic [DATA_WIDTH-1:0]     wdata_d;
   logic [DATA_WIDTH-1:0]     cpu_data_d;
   logic [DATA_WIDTH-1:0]     video_data_d;
   logic [DATA_WIDTH-1:0]     wb_dat_d;

   // Next phase, slot ownership and per-sub-phase SRAM strobes; all outputs
   // are computed for the phase being entered so they register cleanly.
   always_comb begin
      phase_d      = phase_q + PHASE_WIDTH'(1);
      slot_n       = phase_d[5:3];
      sub_n        = phase_d[2:0];
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = ram_addr_o;
      wdata_d      = ram_data_o;
      phi2_d       = phase_d[5];
      oe_d         = 1'b0;
      wen_d        = 1'b0;
      char_stb_d   = 1'b0;
      pixel_stb_d  = 1'b0;
      ack_d        = 1'b0;
      cpu_data_d   = cpu_data_o;
      video_data_d = video_data_o;
      wb_dat_d     = wb_dat_o;

      if (sub_n == SUB_START) begin
         // Slot start: pick the owner and freeze its request for 8 clocks.
         owner_d = OWN_IDLE;
         we_d    = 1'b0;
         if (video_en_i && (slot_n == SLOT_CHAR)) begin
            owner_d = OWN_CHAR;
            addr_d  = video_char_addr_i;
         end else if (video_en_i && (slot_n == SLOT_PIXEL)) begin
            owner_d = OWN_PIXEL;
            addr_d  = video_pixel_addr_i;
         end else if (cpu_en_i && (slot_n == SLOT_CPU)) begin
            owner_d = OWN_CPU;
            we_d    = cpu_we_i;
            addr_d  = cpu_addr_i;
            if (cpu_we_i) begin
               wdata_d = cpu_data_i;
            end
         end else if (wb_cyc_i && wb_stb_i) begin
            owner_d = OWN_WB;
            we_d    = wb_we_i;
            addr_d  = wb_adr_i;
            if (wb_we_i) begin
               wdata_d = wb_dat_i;
            end
         end
      end else if (owner_q != OWN_IDLE) begin
         oe_d  = !we_q && (sub_n != SUB_DONE);
         wen_d = we_q && (sub_n >= SUB_WE_FIRST) && (sub_n <= SUB_WE_LAST);
         if (sub_n == SUB_DONE) begin
            // Last sub-phase: hand read data to its owner.
            case (owner_q)
               OWN_CHAR: begin
                  video_data_d = ram_data_i;
                  char_stb_d   = 1'b1;
               end
               OWN_PIXEL: begin
                  video_data_d = ram_data_i;
                  pixel_stb_d  = 1'b1;
               end
               OWN_CPU: begin
                  if (!we_q) begin
                     cpu_data_d = ram_data_i;
                  end
               end
               OWN_WB: begin
                  if (!we_q) begin
                     wb_dat_d = ram_data_i;
                  end
                  ack_d = wb_cyc_i;
               end
               default: ;
            endcase
         end
      end
   end

   // State and output registers; reset idles the slot and aborts any access.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         phase_q              <= '0;
         owner_q              <= OWN_IDLE;
         we_q                 <= 1'b0;
         cpu_phi2_o           <= 1'b0;
         ram_oe_o             <= 1'b0;
         ram_we_o             <= 1'b0;
         ram_addr_o           <= '0;
         ram_data_o           <= '0;
         cpu_data_o           <= '0;
         video_data_o         <= '0;
         video_char_strobe_o  <= 1'b0;
         video_pixel_strobe_o <= 1'b0;
         wb_dat_o             <= '0;
         wb_ack_o             <= 1'b0;
      end else begin
         phase_q              <= phase_d;
         owner_q              <= owner_d;
         we_q                 <= we_d;
         cpu_phi2_o           <= phi2_d;
         ram_oe_o             <= oe_d;
         ram_we_o             <= wen_d;
         ram_addr_o           <= addr_d;
         ram_data_o           <= wdata_d;
         cpu_data_o           <= cpu_data_d;
         video_data_o         <= video_data_d;
         video_char_strobe_o  <= char_stb_d;
         video_pixel_strobe_o <= pixel_stb_d;
         wb_dat_o             <= wb_dat_d;
         wb_ack_o             <= ack_d;
      end
   end

endmodule
